key_debounce_array: RTL and testbench
=====================================

KEY_DEBOUNCE_ARRAY -- requirements
Module: key_debounce_array

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of independent input channels.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, legal range 2..4: synchroniser flops per channel.
REQ-003 SHALL have parameter STABLE_CYC, default 1_000_000: cycles an input must hold a new level before it is accepted (20 ms at 50 MHz); minimum 2.
REQ-004 SHALL have parameter LONG_CYC, default 50_000_000: cycles in the pressed state before a long-press event fires; LONG_CYC > STABLE_CYC.
REQ-005 SHALL have parameter ACTIVE_LOW, default 1: 1 means an input level of 0 is "pressed".
REQ-006 SHALL have port clk, input, 1 bit: single clock for all logic; no other clock domain.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port in, input, NUM_CH bits: raw asynchronous pin levels.
REQ-009 SHALL have port out, output, NUM_CH bits: debounced level, same polarity as in.
REQ-010 SHALL have port pressed, output, NUM_CH bits: debounced level normalised so that 1 = pressed.
REQ-011 SHALL have ports rise, fall and edj, each output, NUM_CH bits: one-cycle pulses on a debounced 0->1 transition of out, a 1->0 transition of out, and either transition, respectively.
REQ-012 SHALL have port long_press, output, NUM_CH bits: one-cycle pulse when a press has been held for LONG_CYC cycles.
REQ-013 SHALL have port any_pressed, output, 1 bit: OR of pressed.

Function
REQ-014 SHALL pass each in bit through a SYNC_STAGES-deep flop chain; all later logic uses only the synchronised bit.
REQ-015 SHALL give each channel a stability counter of width $clog2(STABLE_CYC); the counter is cleared whenever the synced bit equals out.
REQ-016 SHALL increment the counter each cycle that the synced bit differs from out.
REQ-017 SHALL, when the synced bit differs from out and the counter equals STABLE_CYC-1, invert out at that clock edge and clear the counter.
REQ-018 SHALL therefore change out exactly SYNC_STAGES+STABLE_CYC clock edges after a clean level change on in, with no earlier change.
REQ-019 SHALL discard accumulated count on any glitch: a single cycle with synced == out restarts the qualification from 0.
REQ-020 SHALL register rise/fall/edj on the same edge that out changes, so each pulse is high during the first cycle of the new out level, for exactly 1 cycle.
REQ-021 SHALL compute pressed = out XOR {NUM_CH{ACTIVE_LOW}}, combinationally.
REQ-022 SHALL give each channel a hold counter of width $clog2(LONG_CYC+1) that increments while pressed=1, saturates at LONG_CYC, and clears when pressed=0.
REQ-023 SHALL pulse long_press for 1 cycle on the edge where the hold counter goes from LONG_CYC-1 to LONG_CYC; saturation prevents a repeat until release and re-press.
REQ-024 SHALL abort long-press on release: if pressed falls before LONG_CYC, no long_press is generated and the count restarts on the next press.
REQ-025 SHALL operate channels fully independently; simultaneous events on several channels produce simultaneous pulses with no arbitration.
REQ-026 SHALL have no combinational path from in to any output.

Reset
REQ-027 SHALL, on rst_n low, asynchronously set synchroniser flops and out to the idle level (all 1 if ACTIVE_LOW, else all 0), clear all counters, and drive rise/fall/edj/long_press to 0.
REQ-028 SHALL, after reset, show pressed=0 and any_pressed=0, and produce no edge pulse at reset release when in is at the idle level.
REQ-029 SHALL abandon any partially qualified transition or hold count on reset mid-operation; qualification restarts from 0 after release.

Verification (NUM_CH=4, SYNC_STAGES=2, STABLE_CYC=4, LONG_CYC=10, ACTIVE_LOW=1)
REQ-030 Reset release with in=4'hF -> out=4'hF, pressed=0, no pulses for 20 cycles.
REQ-031 in[0] 1->0 held -> out[0]=0 after exactly 6 edges; fall[0] and edj[0] high for 1 cycle; pressed[0]=1; any_pressed=1.
REQ-032 in[1] low for 3 cycles, high 1 cycle, low again held -> out[1] changes only 6 edges after the final falling edge; no pulse during the glitch.
REQ-033 in[2] held low -> long_press[2] single pulse 10 cycles after pressed[2] rises; no second pulse while held; release -> rise[2] after 6 edges.
REQ-034 in[0] and in[3] fall on the same cycle -> fall[0] and fall[3] pulse on the same cycle.
REQ-035 rst_n asserted 2 cycles into a qualification on in[1] -> out[1] returns to 1 immediately; after release, 6 further edges are required before out[1]=0.

Source files
------------

// File: rtl/key_debounce_array.sv
// Multi-channel key debouncer: synchroniser, stability qualifier,
// edge pulses and long-press detection per channel.
module key_debounce_array #(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int STABLE_CYC  = 1_000_000,
  parameter int LONG_CYC    = 50_000_000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] in,
  output logic [NUM_CH-1:0] out,
  output logic [NUM_CH-1:0] pressed,
  output logic [NUM_CH-1:0] rise,
  output logic [NUM_CH-1:0] fall,
  output logic [NUM_CH-1:0] edj,
  output logic [NUM_CH-1:0] long_press,
  output logic              any_pressed
);

  localparam int SW = (STABLE_CYC > 2) ? $clog2(STABLE_CYC) : 1;
  localparam int HW = $clog2(LONG_CYC + 1);

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYC - 1);
  localparam logic [SW-1:0] STAB_ONE  = SW'(1);
  localparam logic [HW-1:0] HOLD_MAX  = HW'(LONG_CYC);
  localparam logic [HW-1:0] HOLD_PRE  = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] HOLD_ONE  = HW'(1);

  localparam logic [NUM_CH-1:0] IDLE = {NUM_CH{ACTIVE_LOW}};

  logic [SYNC_STAGES-1:0][NUM_CH-1:0] sync_q, sync_d;
  logic [NUM_CH-1:0][SW-1:0] stab_q, stab_d;
  logic [NUM_CH-1:0][HW-1:0] hold_q, hold_d;
  logic [NUM_CH-1:0] out_q, out_d;
  logic [NUM_CH-1:0] rise_q, rise_d;
  logic [NUM_CH-1:0] fall_q, fall_d;
  logic [NUM_CH-1:0] edj_q, edj_d;
  logic [NUM_CH-1:0] long_q, long_d;
  logic [NUM_CH-1:0] synced;
  logic [NUM_CH-1:0] prs;

  assign synced = sync_q[SYNC_STAGES-1];
  assign prs    = out_q ^ IDLE;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], in};
  end

  always_comb begin
    stab_d = '0;
    hold_d = '0;
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    edj_d  = '0;
    long_d = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      // any cycle matching out drops the count back to zero
      if (synced[c] != out_q[c]) begin
        if (stab_q[c] == STAB_LAST) begin
          out_d[c]  = ~out_q[c];
          rise_d[c] = ~out_q[c];
          fall_d[c] = out_q[c];
          edj_d[c]  = 1'b1;
        end else begin
          stab_d[c] = stab_q[c] + STAB_ONE;
        end
      end
      if (prs[c]) begin
        if (hold_q[c] != HOLD_MAX) begin
          hold_d[c] = hold_q[c] + HOLD_ONE;
        end else begin
          hold_d[c] = hold_q[c];
        end
        long_d[c] = (hold_q[c] == HOLD_PRE);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {SYNC_STAGES{IDLE}};
      stab_q <= '0;
      hold_q <= '0;
      out_q  <= IDLE;
      rise_q <= '0;
      fall_q <= '0;
      edj_q  <= '0;
      long_q <= '0;
    end else begin
      sync_q <= sync_d;
      stab_q <= stab_d;
      hold_q <= hold_d;
      out_q  <= out_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      edj_q  <= edj_d;
      long_q <= long_d;
    end
  end

  assign out         = out_q;
  assign pressed     = prs;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign edj         = edj_q;
  assign long_press  = long_q;
  assign any_pressed = |prs;

endmodule

// File: tb/tb_key_debounce_array.sv
// Scoreboard bench for key_debounce_array with small timing
// parameters; expected pulses are queued at stimulus time.
module tb_key_debounce_array;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] in_r = 4'hF;
  logic [3:0] out, pressed, rise, fall, edj, long_press;
  logic       any_pressed;

  always #5 clk = ~clk;

  key_debounce_array #(
    .NUM_CH(4),
    .SYNC_STAGES(2),
    .STABLE_CYC(4),
    .LONG_CYC(10),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in(in_r),
    .out(out),
    .pressed(pressed),
    .rise(rise),
    .fall(fall),
    .edj(edj),
    .long_press(long_press),
    .any_pressed(any_pressed)
  );

  typedef struct {
    int       cyc;
    logic [3:0] r;
    logic [3:0] f;
    logic [3:0] l;
  } ev_t;

  ev_t sb[$];
  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  bit  mon_en = 1'b0;
  logic [3:0] exp_out = 4'hF;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [3:0] r,
                      input logic [3:0] f, input logic [3:0] l);
    ev_t e;
    e.cyc = c;
    e.r = r;
    e.f = f;
    e.l = l;
    sb.push_back(e);
  endtask

  // Pops every event due this cycle and checks all outputs.
  always @(negedge clk) begin : mon
    logic [3:0] er, ef, el;
    er = '0;
    ef = '0;
    el = '0;
    if (mon_en) begin
      if (!rst_n) begin
        exp_out = 4'hF;
        sb.delete();
      end else begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if (sb[i].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL stale_event due=%0d now=%0d", sb[i].cyc, cyc);
            sb.delete(i);
          end else if (sb[i].cyc == cyc) begin
            er = er | sb[i].r;
            ef = ef | sb[i].f;
            el = el | sb[i].l;
            sb.delete(i);
          end
        end
      end
      exp_out = exp_out ^ (er | ef);
      checks++;
      if ({rise, fall, edj, long_press} !== {er, ef, er | ef, el}) begin
        errors++;
        $display("FAIL pulses cyc=%0d got r%h f%h e%h l%h want r%h f%h e%h l%h",
                 cyc, rise, fall, edj, long_press, er, ef, er | ef, el);
      end
      checks++;
      if (out !== exp_out) begin
        errors++;
        $display("FAIL out cyc=%0d got %h want %h", cyc, out, exp_out);
      end
      checks++;
      if (pressed !== ~exp_out || any_pressed !== |(~exp_out)) begin
        errors++;
        $display("FAIL pressed cyc=%0d got %h/%b want %h/%b",
                 cyc, pressed, any_pressed, ~exp_out, |(~exp_out));
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    wait_cyc(2);
    mon_en = 1'b1;
    wait_cyc(2);
    @(posedge clk);
    #2 rst_n = 1'b1;
    wait_cyc(20);
    checks++;
    if (out !== 4'hF || pressed !== 4'h0 || any_pressed !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got out=%h prs=%h any=%b want F/0/0",
               out, pressed, any_pressed);
    end
  endtask

  task automatic test_press;
    int t;
    wait_cyc(1);
    #1 in_r[0] = 1'b0;
    t = cyc;
    push(t + 6, 4'h0, 4'h1, 4'h0);
    wait_cyc(8);
    checks++;
    if (pressed[0] !== 1'b1 || any_pressed !== 1'b1) begin
      errors++;
      $display("FAIL press_level got %b/%b want 1/1", pressed[0], any_pressed);
    end
    #1 in_r[0] = 1'b1;
    push(t + 14, 4'h1, 4'h0, 4'h0);
    wait_cyc(10);
  endtask

  task automatic test_glitch;
    int t;
    wait_cyc(1);
    #1 in_r[1] = 1'b0;
    t = cyc;
    wait_cyc(3);
    #1 in_r[1] = 1'b1;
    wait_cyc(1);
    #1 in_r[1] = 1'b0;
    push(t + 10, 4'h0, 4'h2, 4'h0);
    wait_cyc(5);
    checks++;
    if (out[1] !== 1'b1) begin
      errors++;
      $display("FAIL glitch_early got %b want 1", out[1]);
    end
    wait_cyc(3);
    #1 in_r[1] = 1'b1;
    push(t + 18, 4'h2, 4'h0, 4'h0);
    wait_cyc(10);
    checks++;
    if (pressed[1] !== 1'b0) begin
      errors++;
      $display("FAIL glitch_release got %b want 0", pressed[1]);
    end
  endtask

  task automatic test_long_press;
    int t;
    wait_cyc(1);
    #1 in_r[2] = 1'b0;
    t = cyc;
    push(t + 6, 4'h0, 4'h4, 4'h0);
    push(t + 16, 4'h0, 4'h0, 4'h4);
    wait_cyc(30);
    checks++;
    if (pressed[2] !== 1'b1) begin
      errors++;
      $display("FAIL long_hold got %b want 1", pressed[2]);
    end
    #1 in_r[2] = 1'b1;
    push(t + 36, 4'h4, 4'h0, 4'h0);
    wait_cyc(10);
  endtask

  task automatic test_simultaneous;
    int t;
    wait_cyc(1);
    #1 in_r = in_r & 4'b0110;
    t = cyc;
    push(t + 6, 4'h0, 4'h9, 4'h0);
    wait_cyc(9);
    #1 in_r = in_r | 4'b1001;
    push(t + 15, 4'h9, 4'h0, 4'h0);
    wait_cyc(10);
    checks++;
    if (any_pressed !== 1'b0) begin
      errors++;
      $display("FAIL simul_idle got %b want 0", any_pressed);
    end
  endtask

  task automatic test_reset_mid;
    int r;
    wait_cyc(1);
    #1 in_r[1] = 1'b0;
    wait_cyc(2);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out[1] !== 1'b1 || edj !== 4'h0) begin
      errors++;
      $display("FAIL reset_mid got out1=%b edj=%h want 1/0", out[1], edj);
    end
    wait_cyc(2);
    #2 rst_n = 1'b1;
    r = cyc;
    push(r + 6, 4'h0, 4'h2, 4'h0);
    wait_cyc(8);
    #1 in_r[1] = 1'b1;
    push(r + 14, 4'h2, 4'h0, 4'h0);
    wait_cyc(10);
  endtask

  initial begin
    test_reset();
    test_press();
    test_glitch();
    test_long_press();
    test_simultaneous();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
